// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the div_ctrl multi-cycle divider: state encoding,
// ready flag values, default operand width and iteration count.
package div_ctrl_pkg;

  localparam int DATA_W   = 32;
  localparam int DIV_ITER = 32;

  localparam logic RESULT_READY     = 1'b1;
  localparam logic RESULT_NOT_READY = 1'b0;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_ctrl_step.sv
// div_step: one combinational restoring-division iteration (trial subtract,
// keep-or-restore, emit quotient bit).
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              bit_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              qbit_o
);

  logic [DATA_W:0] trial;

  // Bit DATA_W of the widened difference is the borrow: set means "restore".
  always_comb begin
    trial  = {rem_i, bit_i} - {1'b0, divisor_i};
    qbit_o = ~trial[DATA_W];
    rem_o  = qbit_o ? trial[DATA_W-1:0] : {rem_i[DATA_W-2:0], bit_i};
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: 32-iteration restoring divider (div/divu) with annul support.
// Optional macro DIV_CTRL_ZERO_DETECT_EN short-circuits a zero divisor via BYZERO.
module div_ctrl #(
  parameter int DATA_W = div_ctrl_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);
  import div_ctrl_pkg::*;

  localparam int CNT_W = $clog2(DIV_ITER + 1);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dq_q, dq_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   step_rem;
  logic                step_qbit;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    return (~x) + DATA_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? negate(x) : x;
  endfunction

  // dq_q shifts the dividend out of its MSB while quotient bits enter at the LSB.
  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dq_q[DATA_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dq_d      = dq_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      ST_FREE: begin
        ready_d  = RESULT_NOT_READY;
        result_d = '0;
        cnt_d    = '0;
        if (start_i && !annul_i) begin
          dq_d      = signed_div_i ? abs_val(opdata1_i) : opdata1_i;
          dvs_d     = signed_div_i ? abs_val(opdata2_i) : opdata2_i;
          rem_d     = '0;
          neg_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
          state_d   = ST_ON;
`ifdef DIV_CTRL_ZERO_DETECT_EN
          if (opdata2_i == '0) state_d = ST_BYZERO;
`endif
        end
      end
      // Dwell two cycles so a zero-divisor result lands two edges after acceptance.
      ST_BYZERO: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else begin
          state_d  = ST_END;
          result_d = '0;
          ready_d  = RESULT_READY;
        end
      end
      ST_ON: begin
        if (annul_i) begin
          state_d  = ST_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = RESULT_NOT_READY;
        end else if (cnt_q != CNT_W'(DIV_ITER)) begin
          rem_d = step_rem;
          dq_d  = {dq_q[DATA_W-2:0], step_qbit};
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d  = ST_END;
          result_d = {(neg_rem_q ? negate(rem_q) : rem_q),
                      (neg_quo_q ? negate(dq_q) : dq_q)};
          ready_d  = RESULT_READY;
        end
      end
      ST_END: begin
        if (!start_i) begin
          state_d  = ST_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = RESULT_NOT_READY;
        end
      end
      default: state_d = ST_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dq_q      <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dq_q      <= dq_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: fixed vectors, random operands, annul and async reset.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

`ifdef DIV_CTRL_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  div_ctrl #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] model_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (sgn) return {32'(sa % sb), 32'(sa / sb)};
    return {a % b, a / b};
  endfunction

  // Launch one request, wait for ready, compare, hold in END, then release.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_res, input int hold, input string tag);
    exp_t        e;
    int          lat;
    logic [63:0] held;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    e.res = exp_res;
    e.lat = (ZD && b == 32'd0) ? 2 : 33;
    sb_q.push_back(e);
    lat = -1;
    for (int k = 0; k <= 40 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        lat = k;
      end else begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
      end
    end
    e = sb_q.pop_front();
    check_eq({tag, "_lat"}, 64'(lat), 64'(e.lat));
    check_eq({tag, "_res"}, result_o, e.res);
    held = result_o;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
      check_eq({tag, "_hold_res"}, result_o, held);
    end
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
    check_eq({tag, "_drop_res"}, result_o, 64'd0);
  endtask

  initial begin
    bit          seen;
    bit          sgn;
    logic [31:0] a, b;

    #2;
    check_eq("rst_rdy", 64'(ready_o), 64'd0);
    check_eq("rst_res", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 5, "u100_7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1, "s_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1, "s_7_m2");
    run_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'd3}, 1, "s_m7_m2");
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 1, "u_max_1");
    run_div(1'b1, 32'h8000_0000, 32'd2, {32'd0, 32'hC000_0000}, 1, "s_min_2");
    run_div(1'b0, 32'd3, 32'd10, {32'd3, 32'd0}, 1, "u3_10");
    run_div(1'b0, 32'd5, 32'd0, ZD ? 64'd0 : {32'd5, 32'hFFFF_FFFF}, 1, "div0");

    for (int i = 0; i < 6; i++) begin
      sgn = i[0];
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == 32'd0) b = 32'd3;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd5;
      run_div(sgn, a, b, model_div(sgn, a, b), 1, "rand");
    end

    // Annul after ten iterations: no result may ever appear.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    check_eq("annul_rdy", 64'(ready_o), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1'b1;
    end
    check_eq("annul_never_ready", 64'(seen), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1, "after_annul");

    // Reset while holding a result in END clears outputs without a clock edge.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (34) @(posedge clk);
    #1;
    check_eq("end_rdy", 64'(ready_o), 64'd1);
    check_eq("end_res", result_o, {32'd2, 32'd14});
    #2;
    rst = 1'b0;
    start_i = 1'b0;
    #1;
    check_eq("async_rst_rdy", 64'(ready_o), 64'd0);
    check_eq("async_rst_res", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-ON discards the operation.
    @(negedge clk);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b0;
    start_i = 1'b0;
    #1;
    check_eq("midon_rst_rdy", 64'(ready_o), 64'd0);
    check_eq("midon_rst_res", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1'b1;
    end
    check_eq("midon_discarded", 64'(seen), 64'd0);
    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The parameter SHALL be DATA_W, default 32, giving the operand width; only 32 is required to be supported.
REQ-002 The clock port SHALL be clk, input, 1 bit; all state updates occur on its rising edge.
REQ-003 The reset port SHALL be rst, input, 1 bit; reset is asynchronous and active-low (asserted when 0).
REQ-004 The port signed_div_i SHALL be an input, 1 bit; 1 selects two's-complement (div) and 0 selects unsigned (divu).
REQ-005 The port opdata1_i SHALL be an input, DATA_W bits, carrying the dividend.
REQ-006 The port opdata2_i SHALL be an input, DATA_W bits, carrying the divisor.
REQ-007 The port start_i SHALL be an input, 1 bit, used as the division request level.
REQ-008 The port annul_i SHALL be an input, 1 bit, used to cancel the operation in flight.
REQ-009 The port result_o SHALL be an output, 2*DATA_W bits, with remainder in [63:32] (HI) and quotient in [31:0] (LO), registered.
REQ-010 The port ready_o SHALL be an output, 1 bit, indicating result valid, registered.

Function
REQ-011 The FSM SHALL have four states: FREE, BYZERO, ON and END.
REQ-012 In FREE, when start_i=1 and annul_i=0 on edge E0, the operands and signed_div_i SHALL be latched, and the FSM SHALL go to ON with the iteration counter at 0.
REQ-013 The operands latched at E0 SHALL be the absolute values of the inputs when signed_div_i=1, and the raw inputs otherwise.
REQ-014 In ON, each edge SHALL perform one restoring iteration: trial-subtract the divisor from the upper partial remainder; if the result is non-negative, keep it and shift in 1, otherwise shift in 0.
REQ-015 The counter SHALL increment by 1 per iteration; after 32 iterations (edge E0+32) the FSM SHALL enter END at edge E0+33.
REQ-016 On entry to END, when signed_div_i was 1, the quotient SHALL be negated if the operand signs differed, and the remainder SHALL be negated if the dividend was negative.
REQ-017 On entry to END, result_o SHALL be registered and ready_o SHALL be set to 1.
REQ-018 In END, ready_o and result_o SHALL hold stable while start_i=1; when start_i=0, the next edge SHALL go to FREE with ready_o=0 and result_o=0.
REQ-019 When annul_i=1 in ON, the next edge SHALL go to FREE with ready_o=0; no result SHALL be produced.
REQ-020 When annul_i=1 in FREE, the request SHALL not be accepted.
REQ-021 annul_i SHALL be ignored in BYZERO and in END.
REQ-022 Changes on start_i or the operand inputs during ON SHALL be ignored.
REQ-023 ready_o SHALL be 0 in every state except END.
REQ-024 The counter SHALL never exceed 32 and SHALL be cleared on every entry to FREE or ON.

Reset
REQ-025 While rst=0, the FSM SHALL be in FREE and ready_o, result_o, the counter and all datapath registers SHALL be 0, immediately and without waiting for clk.
REQ-026 A reset asserted mid-ON SHALL discard the operation; after release, the block SHALL accept a new start normally.

Configuration
REQ-027 The feature macro SHALL be DIV_CTRL_ZERO_DETECT_EN.
REQ-028 With DIV_CTRL_ZERO_DETECT_EN defined, acceptance with opdata2_i=0 SHALL go to BYZERO, then END at E0+2 with result_o=0 and ready_o=1.
REQ-029 Without DIV_CTRL_ZERO_DETECT_EN, a zero divisor SHALL take the normal ON path and produce the algorithmic result at E0+33 (unsigned: quotient 0xFFFFFFFF, remainder = dividend).

Structure
REQ-030 A shared package SHALL hold the state encoding (FREE/BYZERO/ON/END), the result-ready/not-ready constants, DATA_W and the iteration count constant (32).
REQ-031 The single sub-module div_step SHALL be a combinational trial-subtract/shift producing the next partial remainder and the quotient bit; div_ctrl SHALL own all registers and the FSM.

Verification
REQ-032 Unsigned 100/7 SHALL yield result_o={0x00000002,0x0000000E}, with ready_o rising at E0+33.
REQ-033 Signed -7/2 (0xFFFFFFF9/0x00000002) SHALL yield remainder 0xFFFFFFFF and quotient 0xFFFFFFFD.
REQ-034 Divisor 0 with dividend 5, unsigned, SHALL yield {0x00000000,0x00000000} at E0+2 with the macro, and {0x00000005,0xFFFFFFFF} at E0+33 without it.
REQ-035 annul_i pulsed at iteration 10 SHALL return the FSM to FREE at the next edge with ready_o never rising; a following 9/3 request SHALL yield {0,3}.
REQ-036 Holding start_i=1 for 5 cycles in END SHALL keep ready_o=1 and result_o stable; dropping start_i SHALL clear ready_o at the next edge.
REQ-037 rst=0 asserted mid-ON, between clock edges, SHALL force ready_o=0 and result_o=0 immediately, and a subsequent 100/7 request SHALL complete correctly.
